// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//   Passive-buzzer melody engine. Note commands (tone, duration) are queued in
//   a small FIFO through a valid/ready handshake and played back-to-back as
//   square waves on piano_out. Half-period terminal counts for every tone are
//   derived from CLK_HZ at elaboration.
//
// Ports
//   clk_in      system clock
//   rst_n_in    asynchronous reset, active-low
//   tone_en     play enable; low pauses playback (counters frozen, output 0)
//   clr         synchronous flush: empty FIFO, abort current note
//   note_valid  note command valid
//   note_ready  FIFO can accept a command (not full)
//   note_tone   0 = rest, 1..7 = L1..L7, 8..14 = M1..M7, 15..21 = H1..H7,
//               22..31 = rest
//   note_dur    note length in beats
//   piano_out   buzzer drive
//   busy        not IDLE, or FIFO non-empty
//   note_done   one-cycle pulse when a note (or zero-duration entry) retires
//   fifo_level  current FIFO occupancy
//
// Build option
//   NOTE_GAP_EN  when defined, GAP_CYCLES of silence follow every sounded note.
//
// States
//   IDLE | waiting for a FIFO entry while tone_en is high
//   PLAY | sounding (or resting) the loaded note
//   GAP  | silence between notes (NOTE_GAP_EN only)
// -----------------------------------------------------------------------------
module tone_sequencer #(
    parameter int CLK_HZ      = 12000000,
    parameter int BEAT_CYCLES = 750000,
    parameter int DUR_W       = 8,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 18,
    parameter int GAP_CYCLES  = 60000
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     tone_en,
    input  logic                     clr,
    input  logic                     note_valid,
    output logic                     note_ready,
    input  logic [4:0]               note_tone,
    input  logic [DUR_W-1:0]         note_dur,
    output logic                     piano_out,
    output logic                     busy,
    output logic                     note_done,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 0) begin : g_bad_params
        $error("tone_sequencer: DEPTH must be a power of 2 >= 2 and GAP_CYCLES >= 0");
    end

    // Frequencies in tenths of Hz; M and H octaves are the L values doubled
    // and quadrupled. Anything outside 1..21 is a rest.
    function automatic longint f10_of(input int idx);
        longint base;
        longint res;
        base = 0;
        res  = 0;
        if (idx >= 1 && idx <= 21) begin
            case ((idx - 1) % 7)
                0:       base = 2616;
                1:       base = 2937;
                2:       base = 3296;
                3:       base = 3492;
                4:       base = 3920;
                5:       base = 4400;
                default: base = 4939;
            endcase
            res = base << ((idx - 1) / 7);
        end
        return res;
    endfunction

    logic [CNT_W-1:0] tend_tab [32];
    logic [31:0]      rest_tab;

    for (genvar g = 0; g < 32; g++) begin : g_tend
        localparam longint F10  = f10_of(g);
        localparam longint TEND = (F10 == 0) ? 64'sd0 : (longint'(CLK_HZ) * 5) / F10 - 1;
        assign tend_tab[g] = TEND[CNT_W-1:0];
        assign rest_tab[g] = (F10 == 0);
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and pointers
    logic [4:0]       mem_tone_q [DEPTH];
    logic [DUR_W-1:0] mem_dur_q  [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    count_q;

    // Playback datapath
    logic [CNT_W-1:0] tone_cnt_q, tone_cnt_d;
    logic [CNT_W-1:0] tend_q, tend_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [DUR_W-1:0] dur_rem_q, dur_rem_d;
    logic             rest_q, rest_d;
    logic             piano_q, piano_d;
    logic             done_q, done_d;

    logic             push, pop, load;
    logic             fifo_empty, head_ok;
    logic [4:0]       head_tone;
    logic [DUR_W-1:0] head_dur;
    logic             tone_wrap, beat_wrap, note_end;

    assign head_tone  = mem_tone_q[rd_ptr_q];
    assign head_dur   = mem_dur_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    // A zero-duration head is never loaded straight out of a note end; IDLE
    // retires it on the following edge so it still gets its own pulse.
    assign head_ok    = !fifo_empty && (head_dur != '0);
    assign push       = note_valid && note_ready && !clr;
    assign tone_wrap  = (tone_cnt_q == tend_q);
    assign beat_wrap  = (beat_cnt_q == BEAT_LAST);
    assign note_end   = (state_q == S_PLAY) && tone_en && beat_wrap
                        && (dur_rem_q == DUR_W'(1));

`ifdef NOTE_GAP_EN
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          gap_end;
    assign gap_end = (state_q == S_GAP) && tone_en && (gap_cnt_q == GAP_LAST);
`endif

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and FIFO pop / load decisions
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        done_d  = 1'b0;
        if (clr) begin
            state_d = S_IDLE;
        end else if (tone_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (head_dur == '0) begin
                            done_d = 1'b1;
                        end else begin
                            load    = 1'b1;
                            state_d = S_PLAY;
                        end
                    end
                end
                S_PLAY: begin
                    if (note_end) begin
                        done_d = 1'b1;
`ifdef NOTE_GAP_EN
                        state_d = S_GAP;
`else
                        if (head_ok) begin
                            pop  = 1'b1;
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
`endif
                    end
                end
`ifdef NOTE_GAP_EN
                S_GAP: begin
                    if (gap_end) begin
                        if (head_ok) begin
                            pop     = 1'b1;
                            load    = 1'b1;
                            state_d = S_PLAY;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        note_ready = (count_q != LW'(DEPTH));
        fifo_level = count_q;
        busy       = (state_q != S_IDLE) || !fifo_empty;
        // Pausing masks the output but keeps piano_q, so phase resumes intact.
        piano_out  = piano_q && tone_en;
        note_done  = done_q;
    end

    // Playback datapath next-state
    always_comb begin
        tone_cnt_d = tone_cnt_q;
        beat_cnt_d = beat_cnt_q;
        dur_rem_d  = dur_rem_q;
        tend_d     = tend_q;
        rest_d     = rest_q;
        piano_d    = piano_q;
        if (load) begin
            tone_cnt_d = '0;
            beat_cnt_d = '0;
            dur_rem_d  = head_dur;
            tend_d     = tend_tab[head_tone];
            rest_d     = rest_tab[head_tone];
            piano_d    = 1'b0;
        end else if (state_q == S_PLAY && tone_en) begin
            if (note_end) begin
                tone_cnt_d = '0;
                beat_cnt_d = '0;
                dur_rem_d  = '0;
                piano_d    = 1'b0;
            end else begin
                tone_cnt_d = tone_wrap ? '0 : tone_cnt_q + CNT_W'(1);
                if (tone_wrap && !rest_q) begin
                    piano_d = ~piano_q;
                end
                if (beat_wrap) begin
                    beat_cnt_d = '0;
                    dur_rem_d  = dur_rem_q - DUR_W'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
            end
        end
        if (clr) begin
            tone_cnt_d = '0;
            beat_cnt_d = '0;
            dur_rem_d  = '0;
            piano_d    = 1'b0;
        end
    end

`ifdef NOTE_GAP_EN
    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (clr || note_end || gap_end) begin
            gap_cnt_d = '0;
        end else if (state_q == S_GAP && tone_en) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tone_cnt_q <= '0;
            beat_cnt_q <= '0;
            dur_rem_q  <= '0;
            tend_q     <= '0;
            rest_q     <= 1'b0;
            piano_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            dur_rem_q  <= dur_rem_d;
            tend_q     <= tend_d;
            rest_q     <= rest_d;
            piano_q    <= piano_d;
            done_q     <= done_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_tone_q[wr_ptr_q] <= note_tone;
            mem_dur_q[wr_ptr_q]  <= note_dur;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + LW'(push) - LW'(pop);
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench clock scaled so L1 half-period = 100, M1 = 50, H1 = 25 cycles,
// one beat = 300 cycles. Expected note_done cycle, high-sample count and
// rising-edge count per note are queued by the stimulus and popped by the
// monitor on every note_done pulse.
module tb_tone_sequencer;

    localparam int CLK_HZ      = 52320;
    localparam int BEAT_CYCLES = 300;
    localparam int DUR_W       = 8;
    localparam int DEPTH       = 8;
    localparam int CNT_W       = 18;
    localparam int GAP_CYCLES  = 1000;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             tone_en;
    logic             clr;
    logic             note_valid;
    logic             note_ready;
    logic [4:0]       note_tone;
    logic [DUR_W-1:0] note_dur;
    logic             piano_out;
    logic             busy;
    logic             note_done;
    logic [3:0]       fifo_level;

    tone_sequencer #(
        .CLK_HZ      (CLK_HZ),
        .BEAT_CYCLES (BEAT_CYCLES),
        .DUR_W       (DUR_W),
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .tone_en    (tone_en),
        .clr        (clr),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_tone  (note_tone),
        .note_dur   (note_dur),
        .piano_out  (piano_out),
        .busy       (busy),
        .note_done  (note_done),
        .fifo_level (fifo_level)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cyc;
        int high;
        int rises;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   hi_cnt = 0;
    int   rise_cnt = 0;
    logic prev_p = 1'b0;
    exp_t e_mon;

    always @(posedge clk_in) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: one scoreboard entry per note_done pulse.
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (note_done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_note_done: pulse at cycle %0d, none required", cyc);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("done_cycle", cyc, e_mon.cyc);
                    check("high_cycles", hi_cnt, e_mon.high);
                    check("rises", rise_cnt, e_mon.rises);
                end
                hi_cnt   = 0;
                rise_cnt = 0;
            end
            if (piano_out) begin
                hi_cnt++;
                if (!prev_p) rise_cnt++;
            end
            prev_p = piano_out;
            if (clr) begin
                hi_cnt   = 0;
                rise_cnt = 0;
            end
        end
    end

    task automatic expect_done(input int c, input int h, input int r);
        exp_t x;
        x.cyc   = c;
        x.high  = h;
        x.rises = r;
        exp_q.push_back(x);
    endtask

    task automatic push(input logic [4:0] t, input logic [DUR_W-1:0] d, output int k);
        note_tone  = t;
        note_dur   = d;
        note_valid = 1'b1;
        @(posedge clk_in);
        #1;
        k          = cyc;
        note_valid = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d note_done pulses still pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int k, k2, t, l;
        logic bad;
        rst_n_in   = 1'b0;
        tone_en    = 1'b0;
        clr        = 1'b0;
        note_valid = 1'b0;
        note_tone  = '0;
        note_dur   = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_note_ready", note_ready, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_piano_out", piano_out, 0);
        check("rst_note_done", note_done, 0);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        tone_en = 1'b1;

        // L1, two beats: first rise exactly one half-period after load
        push(5'd1, 8'd2, k);
        expect_done(k + 601, 300, 3);
        wait_until(k + 100);
        check("l1_before_rise", piano_out, 0);
        @(posedge clk_in);
        #1;
        check("l1_first_rise", piano_out, 1);
        check("l1_busy_playing", busy, 1);
        wait_empty(2000);
        check("l1_busy_after", busy, 0);

        // M1 then H1 back-to-back; push and load pop on the same edge
        push(5'd8, 8'd1, k);
        push(5'd15, 8'd1, k2);
        check("m1h1_level_push_pop", fifo_level, 1);
        expect_done(k + 301, 150, 3);
        expect_done(k + 601, 150, 6);
        wait_empty(2000);

        // Fill while paused: 9 attempts, 8 accepted
        tone_en = 1'b0;
        for (int i = 0; i < 8; i++) push(5'd15, 8'd1, k);
        check("full_note_ready", note_ready, 0);
        check("full_level", fifo_level, 8);
        check("full_busy_paused", busy, 1);
        push(5'd15, 8'd1, k);
        check("full_reject_level", fifo_level, 8);
        t = cyc;
        tone_en = 1'b1;
        for (int i = 1; i <= 8; i++) expect_done(t + 1 + 300 * i, 150, 6);
        wait_empty(4000);

        // Pause for 500 cycles mid-note
        push(5'd1, 8'd2, k);
        l = k + 1;
        expect_done(l + 1100, 300, 4);
        wait_until(l + 150);
        check("pause_pre_high", piano_out, 1);
        tone_en = 1'b0;
        bad = 1'b0;
        repeat (500) begin
            @(posedge clk_in);
            #1;
            if (piano_out) bad = 1'b1;
        end
        check("pause_output_silent", bad, 0);
        tone_en = 1'b1;
        #1;
        check("pause_phase_restored", piano_out, 1);
        wait_empty(2000);

        // Rests and a zero-duration entry
        push(5'd0, 8'd3, k);
        push(5'd25, 8'd1, k2);
        push(5'd5, 8'd0, k2);
        expect_done(k + 901, 0, 0);
        expect_done(k + 1201, 0, 0);
        expect_done(k + 1202, 0, 0);
        wait_empty(3000);
        check("rest_busy_after", busy, 0);

        // clr mid-note with 3 queued, a push attempted on the same edge
        push(5'd1, 8'd2, k);
        for (int i = 0; i < 3; i++) push(5'd1, 8'd1, k2);
        check("clr_level_before", fifo_level, 3);
        wait_until(k + 120);
        check("clr_pre_high", piano_out, 1);
        clr        = 1'b1;
        note_valid = 1'b1;
        note_tone  = 5'd1;
        note_dur   = 8'd1;
        @(posedge clk_in);
        #1;
        clr        = 1'b0;
        note_valid = 1'b0;
        check("clr_level", fifo_level, 0);
        check("clr_piano", piano_out, 0);
        check("clr_busy", busy, 0);
        check("clr_note_done", note_done, 0);
        check("clr_note_ready", note_ready, 1);
        repeat (1500) @(posedge clk_in);
        #1;
        check("clr_still_idle", busy, 0);

        check("leftover_expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
